led_step_ctrl: RTL
==================

Name: led_step_ctrl

Overview:
- Upstream controller for the 8-bit LED pattern stages (inside-out, outside-in, etc.).
- Turns raw push-button inputs into clean controls and produces a programmable-rate single-cycle step enable that advances the pattern stage.
- Counts completed pattern frames reported back by the pattern stage.
- Advances a pattern-mode selector after a fixed number of frames.

Parameters:
DIV_W, 24, width of the prescaler counter and of div_val.
FRAMES_PER_MODE, 4, completed frames per mode before mode advances (>=1).
MODE_W, 2, width of the mode selector; mode wraps at 2**MODE_W-1.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
run_btn  input  1  asynchronous button level; each rising edge toggles run/pause.
step_btn  input  1  asynchronous button level; each rising edge requests one manual step while not running.
div_val  input  DIV_W  step period minus one, in clk cycles; sampled every cycle.
frame_done  input  1  one-cycle pulse from the pattern stage when its pattern wraps (all-ones -> zero).
step  output  1  registered one-cycle step enable to the pattern stage.
running  output  1  1 while in RUN state.
mode  output  MODE_W  current pattern-mode select.
frame_cnt  output  8  frames completed in the current mode.

Behaviour:
- Reset (synchronous, highest priority, overrides every other event in that cycle):
  - state=IDLE; step=0; running=0; mode=0; frame_cnt=0.
  - Prescaler count=0; synchronizer and edge flops=0.
- Button conditioning: each button passes through a 2-FF synchronizer (s1, s2) and a history flop s3; edge = s2 & ~s3.
  - Input high at rising edge k -> edge asserted between edges k+1 and k+2 -> action registered at edge k+2.
  - A held button produces exactly one edge. No debounce filtering; bounce yields multiple edges by design.
- States: IDLE, RUN, SINGLE.
  - IDLE: step=0, prescaler held at 0.
    - run edge -> RUN (count cleared).
    - step edge -> SINGLE.
  - SINGLE: step=1 for exactly one cycle, then IDLE. Edges arriving during SINGLE are dropped.
  - RUN: running=1; count increments each cycle.
    - When count >= div_val: step=1 next cycle and count <= 0.
    - run edge -> IDLE, count cleared; any step pending on that edge is suppressed.
    - step edges are ignored in RUN.
- Step period and latency:
  - Step period = div_val+1 cycles; div_val=0 gives step every cycle.
  - First step after entering RUN occurs div_val+1 cycles after running rises.
  - Comparison uses >= so lowering div_val mid-count fires on the next cycle, never wraps the counter.
- Simultaneous run edge and step edge in IDLE: run wins -> RUN; step edge discarded.
- Frame counting (all states, including IDLE):
  - On frame_done: if frame_cnt == FRAMES_PER_MODE-1, then frame_cnt <= 0 and mode <= mode+1 (wraps 2**MODE_W-1 -> 0); else frame_cnt <= frame_cnt+1.
  - mode changes take effect on the cycle after the frame_done pulse. Downstream latches mode only on frame boundaries.
- frame_done in the same cycle as reset: ignored.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset with all inputs 0, hold 10 cycles -> step=0, running=0, mode=0, frame_cnt=0 throughout; assert reset mid-RUN -> all outputs reset on the next edge.
2. div_val=3, run_btn pulse high 5 cycles -> running=1 at the 3rd edge after the rise; step pulses every 4 cycles, first 4 cycles after running rises; no double step for the held button.
3. div_val=0 in RUN -> step=1 every cycle; change div_val 9->2 while count=5 -> step next cycle, then every 3 cycles.
4. In IDLE, step_btn pulse -> exactly one step pulse 3 cycles after the rise, state back to IDLE; step_btn while running -> no extra step.
5. run_btn and step_btn rise on the same edge in IDLE -> enters RUN, no SINGLE step; second run_btn pulse -> running=0, step stays 0.
6. FRAMES_PER_MODE=4: 4 frame_done pulses -> frame_cnt 1,2,3,0 with mode 0->1 on the 4th; 16 pulses total -> mode wraps 3->0; frame_done during IDLE still counted.

Source files
------------

// File: rtl/led_step_ctrl.sv
// Step-enable controller for the LED pattern stages: synchronises the run/step
// buttons, generates a programmable-rate step pulse, and cycles pattern modes.
module led_step_ctrl #(
  parameter int DIV_W           = 24,
  parameter int FRAMES_PER_MODE = 4,
  parameter int MODE_W          = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_btn,
  input  logic              step_btn,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              frame_done,
  output logic              step,
  output logic              running,
  output logic [MODE_W-1:0] mode,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SINGLE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_MODE - 1);

  logic [1:0] btn_raw;
  logic [1:0] btn_edge;
  logic       run_edge;
  logic       step_edge;

  assign btn_raw   = {step_btn, run_btn};
  assign run_edge  = btn_edge[0];
  assign step_edge = btn_edge[1];

  // Two-flop synchroniser plus a history flop per button; a held button
  // yields a single rising-edge pulse, bounce is passed through untouched.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic s1_q;
      logic s2_q;
      logic s3_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
          s3_q <= 1'b0;
        end else begin
          s1_q <= btn_raw[gi];
          s2_q <= s1_q;
          s3_q <= s2_q;
        end
      end

      assign btn_edge[gi] = s2_q & ~s3_q;
    end
  endgenerate

  state_t             state_q;
  state_t             state_d;
  logic [DIV_W-1:0]   count_q;
  logic [DIV_W-1:0]   count_d;
  logic               step_q;
  logic               step_d;
  logic               running_q;
  logic               running_d;
  logic [MODE_W-1:0]  mode_q;
  logic [MODE_W-1:0]  mode_d;
  logic [7:0]         frame_cnt_q;
  logic [7:0]         frame_cnt_d;
  logic               fire;

  // ">=" lets a lowered div_val take effect immediately instead of wrapping.
  assign fire = (state_q == ST_RUN) && (count_q >= div_val);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      step_q    <= step_d;
      running_q <= running_d;
    end
  end

  // Next-state and prescaler
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (run_edge) begin
          state_d = ST_RUN;
        end else if (step_edge) begin
          state_d = ST_SINGLE;
        end
      end
      ST_RUN: begin
        if (run_edge) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (fire) begin
          count_d = '0;
        end else begin
          count_d = count_q + DIV_W'(1);
        end
      end
      ST_SINGLE: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs are computed from the transition so the registered pulse lines up
  // with entry into SINGLE or with a prescaler wrap; a run edge kills any step.
  always_comb begin
    step_d    = 1'b0;
    running_d = (state_d == ST_RUN);
    if (!run_edge) begin
      if (state_q == ST_IDLE && step_edge) begin
        step_d = 1'b1;
      end else if (fire) begin
        step_d = 1'b1;
      end
    end
  end

  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_done) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        mode_d      = mode_q + MODE_W'(1);
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign step      = step_q;
  assign running   = running_q;
  assign mode      = mode_q;
  assign frame_cnt = frame_cnt_q;

endmodule
